// File: rtl/vrail_monitor.sv
// Rail monitor: turns a streamed multi-channel ADC feed into debounced, hysteretic
// power-good / VIN-fault levels and sticky OV/UV/bad-channel flags for the sequencer.
module vrail_monitor #(
    parameter int                VRAILS     = 4,
    parameter int                ADC_W      = 12,
    parameter int                GLITCH_CNT = 3,
    parameter logic [ADC_W-1:0]  VIN_ON     = ADC_W'(12'hA00),
    parameter logic [ADC_W-1:0]  VIN_OFF    = ADC_W'(12'h980)
) (
    input  logic                    CLOCK,
    input  logic                    RESET_N,
    input  logic                    ADC_VALID,
    output logic                    ADC_READY,
    input  logic [3:0]              ADC_CHANNEL,
    input  logic [ADC_W-1:0]        ADC_DATA,
    input  logic [VRAILS*ADC_W-1:0] PG_ON,
    input  logic [VRAILS*ADC_W-1:0] PG_OFF,
    input  logic [VRAILS*ADC_W-1:0] OV_THRESH,
    input  logic [VRAILS-1:0]       VMON_ENA,
    input  logic                    CLR_FAULTS,
    output logic [VRAILS-1:0]       VRAIL_PWRGD,
    output logic                    VIN_FAULT,
    output logic [VRAILS-1:0]       OV_FLAG,
    output logic [VRAILS-1:0]       UV_FLAG,
    output logic                    BAD_CHAN
);

    localparam logic [3:0] VIN_CH   = 4'(VRAILS);
    localparam logic [3:0] CNT_LAST = 4'(GLITCH_CNT - 1);
    localparam logic [3:0] CNT_SAT  = 4'(GLITCH_CNT);

    typedef enum logic {ST_LOW, ST_HIGH} pg_state_t;

    typedef struct packed {
        logic      fell;
        pg_state_t st;
        logic [3:0] cnt;
    } pg_next_t;

    // Handshake: a sample moves when ADC_VALID && ADC_READY at a rising edge;
    // ADC_READY is held high whenever out of reset, so the feed is never stalled.
    logic                    r_ready;
    logic                    r_s1_vld;
    logic [3:0]              r_s1_ch;
    logic [ADC_W-1:0]        r_s1_data;

    logic                    r_s2_vld;
    logic                    r_s2_bad;
    logic [3:0]              r_s2_ch;
    logic                    r_s2_ge_on;
    logic                    r_s2_lt_off;
    logic                    r_s2_gt_ov;

    pg_state_t               r_rail_st [VRAILS];
    logic [3:0]              r_rail_cnt [VRAILS];
    logic [3:0]              r_ov_cnt [VRAILS];
    pg_state_t               r_vin_st;
    logic [3:0]              r_vin_cnt;
    logic [VRAILS-1:0]       r_ov;
    logic [VRAILS-1:0]       r_uv;
    logic                    r_bad;

    logic                    w_xfer;
    logic                    w_ch_ok;
    logic                    w_is_rail;
    logic [ADC_W-1:0]        w_on;
    logic [ADC_W-1:0]        w_off;
    logic [ADC_W-1:0]        w_ov;
    pg_next_t                w_rail_nxt [VRAILS];
    pg_next_t                w_vin_nxt;

    function automatic pg_next_t pg_step(input pg_state_t st, input logic [3:0] cnt,
                                         input logic ge_on, input logic lt_off);
        pg_next_t n;
        n.fell = 1'b0;
        n.st   = st;
        n.cnt  = '0;
        if (st == ST_LOW) begin
            if (ge_on) begin
                if (cnt == CNT_LAST) n.st  = ST_HIGH;
                else                 n.cnt = cnt + 4'd1;
            end
        end else if (lt_off) begin
            if (cnt == CNT_LAST) begin
                n.st   = ST_LOW;
                n.fell = 1'b1;
            end else begin
                n.cnt = cnt + 4'd1;
            end
        end
        return n;
    endfunction

    assign w_xfer  = ADC_VALID && r_ready;
    assign w_ch_ok = (r_s1_ch <= VIN_CH);

    always_ff @(posedge CLOCK) begin
        if (!RESET_N) begin
            r_ready   <= 1'b0;
            r_s1_vld  <= 1'b0;
            r_s1_ch   <= '0;
            r_s1_data <= '0;
        end else begin
            r_ready  <= 1'b1;
            r_s1_vld <= w_xfer;
            if (w_xfer) begin
                r_s1_ch   <= ADC_CHANNEL;
                r_s1_data <= ADC_DATA;
            end
        end
    end

    // VIN has no OV threshold; the all-ones default can never be exceeded.
    always_comb begin
        w_on      = VIN_ON;
        w_off     = VIN_OFF;
        w_ov      = '1;
        w_is_rail = 1'b0;
        for (int i = 0; i < VRAILS; i++) begin
            if (r_s1_ch == 4'(i)) begin
                w_on      = PG_ON[i*ADC_W +: ADC_W];
                w_off     = PG_OFF[i*ADC_W +: ADC_W];
                w_ov      = OV_THRESH[i*ADC_W +: ADC_W];
                w_is_rail = 1'b1;
            end
        end
    end

    always_ff @(posedge CLOCK) begin
        if (!RESET_N) begin
            r_s2_vld    <= 1'b0;
            r_s2_bad    <= 1'b0;
            r_s2_ch     <= '0;
            r_s2_ge_on  <= 1'b0;
            r_s2_lt_off <= 1'b0;
            r_s2_gt_ov  <= 1'b0;
        end else begin
            r_s2_vld    <= r_s1_vld && w_ch_ok;
            r_s2_bad    <= r_s1_vld && !w_ch_ok;
            r_s2_ch     <= r_s1_ch;
            r_s2_ge_on  <= (r_s1_data >= w_on);
            r_s2_lt_off <= (r_s1_data < w_off);
            r_s2_gt_ov  <= w_is_rail && (r_s1_data > w_ov);
        end
    end

    always_comb begin
        for (int i = 0; i < VRAILS; i++) begin
            w_rail_nxt[i] = pg_step(r_rail_st[i], r_rail_cnt[i], r_s2_ge_on, r_s2_lt_off);
        end
        w_vin_nxt = pg_step(r_vin_st, r_vin_cnt, r_s2_ge_on, r_s2_lt_off);
    end

    // Clears are written first so a set landing on the same edge takes precedence.
    always_ff @(posedge CLOCK) begin
        if (!RESET_N) begin
            for (int i = 0; i < VRAILS; i++) begin
                r_rail_st[i]  <= ST_LOW;
                r_rail_cnt[i] <= '0;
                r_ov_cnt[i]   <= '0;
            end
            r_vin_st  <= ST_LOW;
            r_vin_cnt <= '0;
            r_ov      <= '0;
            r_uv      <= '0;
            r_bad     <= 1'b0;
        end else begin
            if (CLR_FAULTS) begin
                r_ov  <= '0;
                r_uv  <= '0;
                r_bad <= 1'b0;
            end
            if (r_s2_bad) r_bad <= 1'b1;
            for (int i = 0; i < VRAILS; i++) begin
                if (r_s2_vld && r_s2_ch == 4'(i)) begin
                    r_rail_st[i]  <= w_rail_nxt[i].st;
                    r_rail_cnt[i] <= w_rail_nxt[i].cnt;
                    if (w_rail_nxt[i].fell && VMON_ENA[i]) r_uv[i] <= 1'b1;
                    if (r_s2_gt_ov) begin
                        if (r_ov_cnt[i] >= CNT_LAST) begin
                            r_ov[i]     <= 1'b1;
                            r_ov_cnt[i] <= CNT_SAT;
                        end else begin
                            r_ov_cnt[i] <= r_ov_cnt[i] + 4'd1;
                        end
                    end else begin
                        r_ov_cnt[i] <= '0;
                    end
                end
            end
            if (r_s2_vld && r_s2_ch == VIN_CH) begin
                r_vin_st  <= w_vin_nxt.st;
                r_vin_cnt <= w_vin_nxt.cnt;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < VRAILS; i++) begin
            VRAIL_PWRGD[i] = (r_rail_st[i] == ST_HIGH);
        end
    end

    assign ADC_READY = r_ready;
    assign VIN_FAULT = (r_vin_st == ST_LOW);
    assign OV_FLAG   = r_ov;
    assign UV_FLAG   = r_uv;
    assign BAD_CHAN  = r_bad;

endmodule

// File: tb/tb_vrail_monitor.sv
// Bench for vrail_monitor: directed scenarios plus randomized bursts checked against
// a per-channel behavioural model of the debounce, hysteresis and sticky-flag rules.
module tb_vrail_monitor;

    localparam int          VRAILS  = 4;
    localparam int          ADC_W   = 12;
    localparam int          G       = 3;
    localparam logic [11:0] VIN_ON  = 12'hA00;
    localparam logic [11:0] VIN_OFF = 12'h980;

    logic                    CLOCK;
    logic                    RESET_N;
    logic                    ADC_VALID;
    logic                    ADC_READY;
    logic [3:0]              ADC_CHANNEL;
    logic [ADC_W-1:0]        ADC_DATA;
    logic [VRAILS*ADC_W-1:0] PG_ON;
    logic [VRAILS*ADC_W-1:0] PG_OFF;
    logic [VRAILS*ADC_W-1:0] OV_THRESH;
    logic [VRAILS-1:0]       VMON_ENA;
    logic                    CLR_FAULTS;
    logic [VRAILS-1:0]       VRAIL_PWRGD;
    logic                    VIN_FAULT;
    logic [VRAILS-1:0]       OV_FLAG;
    logic [VRAILS-1:0]       UV_FLAG;
    logic                    BAD_CHAN;

    logic [11:0] pg_on  [VRAILS];
    logic [11:0] pg_off [VRAILS];
    logic [11:0] ov_th  [VRAILS];

    for (genvar g = 0; g < VRAILS; g++) begin : g_pack
        assign PG_ON[g*ADC_W +: ADC_W]     = pg_on[g];
        assign PG_OFF[g*ADC_W +: ADC_W]    = pg_off[g];
        assign OV_THRESH[g*ADC_W +: ADC_W] = ov_th[g];
    end

    vrail_monitor #(
        .VRAILS(VRAILS), .ADC_W(ADC_W), .GLITCH_CNT(G), .VIN_ON(VIN_ON), .VIN_OFF(VIN_OFF)
    ) dut (
        .CLOCK(CLOCK), .RESET_N(RESET_N), .ADC_VALID(ADC_VALID), .ADC_READY(ADC_READY),
        .ADC_CHANNEL(ADC_CHANNEL), .ADC_DATA(ADC_DATA), .PG_ON(PG_ON), .PG_OFF(PG_OFF),
        .OV_THRESH(OV_THRESH), .VMON_ENA(VMON_ENA), .CLR_FAULTS(CLR_FAULTS),
        .VRAIL_PWRGD(VRAIL_PWRGD), .VIN_FAULT(VIN_FAULT), .OV_FLAG(OV_FLAG),
        .UV_FLAG(UV_FLAG), .BAD_CHAN(BAD_CHAN)
    );

    // ---------------- clock / reset ----------------
    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- reference model ----------------
    bit                m_good [VRAILS+1];
    int                m_run  [VRAILS+1];
    int                m_ovrun[VRAILS];
    logic [VRAILS-1:0] m_ov, m_uv;
    logic              m_bad;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic m_reset();
        for (int i = 0; i <= VRAILS; i++) begin m_good[i] = 0; m_run[i] = 0; end
        for (int i = 0; i < VRAILS; i++) m_ovrun[i] = 0;
        m_ov = '0; m_uv = '0; m_bad = 1'b0;
    endtask

    task automatic m_clear();
        m_ov = '0; m_uv = '0; m_bad = 1'b0;
    endtask

    // A channel changes level after G consecutive samples on the far side of the
    // relevant threshold; any other sample of that channel restarts the run.
    task automatic m_apply(input int ch, input int d);
        int on, off;
        bit qual;
        if (ch > VRAILS) begin
            m_bad = 1'b1;
            return;
        end
        on  = (ch == VRAILS) ? int'(VIN_ON)  : int'(pg_on[ch]);
        off = (ch == VRAILS) ? int'(VIN_OFF) : int'(pg_off[ch]);
        qual = m_good[ch] ? (d < off) : (d >= on);
        m_run[ch] = qual ? m_run[ch] + 1 : 0;
        if (m_run[ch] == G) begin
            m_run[ch] = 0;
            if (m_good[ch] && ch < VRAILS && VMON_ENA[ch]) m_uv[ch] = 1'b1;
            m_good[ch] = !m_good[ch];
        end
        if (ch < VRAILS) begin
            m_ovrun[ch] = (d > int'(ov_th[ch])) ? m_ovrun[ch] + 1 : 0;
            if (m_ovrun[ch] >= G) m_ov[ch] = 1'b1;
        end
    endtask

    function automatic logic [VRAILS-1:0] m_pg();
        logic [VRAILS-1:0] r;
        for (int i = 0; i < VRAILS; i++) r[i] = m_good[i];
        return r;
    endfunction

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, "_pwrgd"}, 32'(VRAIL_PWRGD), 32'(m_pg()));
        check({tag, "_vin_fault"}, 32'(VIN_FAULT), 32'(!m_good[VRAILS]));
        check({tag, "_ov"}, 32'(OV_FLAG), 32'(m_ov));
        check({tag, "_uv"}, 32'(UV_FLAG), 32'(m_uv));
        check({tag, "_bad"}, 32'(BAD_CHAN), 32'(m_bad));
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge CLOCK);
        #1;
    endtask

    // Leaves ADC_VALID high so consecutive calls form a back-to-back stream.
    task automatic send(input logic [3:0] ch, input logic [11:0] d);
        int  budget;
        bit  rdy;
        ADC_VALID   = 1'b1;
        ADC_CHANNEL = ch;
        ADC_DATA    = d;
        budget = 0;
        do begin
            rdy = ADC_READY;
            step();
            budget++;
        end while (!rdy && budget < 20);
        if (!rdy) check("ready_timeout", 32'(rdy), 32'd1);
        else      m_apply(int'(ch), int'(d));
    endtask

    task automatic idle(input int n);
        ADC_VALID = 1'b0;
        repeat (n) step();
    endtask

    task automatic clr_pulse();
        CLR_FAULTS = 1'b1;
        step();
        CLR_FAULTS = 1'b0;
        m_clear();
    endtask

    function automatic logic [11:0] pick_val(input int ch);
        int on, off, ov, v;
        on  = (ch == VRAILS) ? int'(VIN_ON)  : int'(pg_on[ch]);
        off = (ch == VRAILS) ? int'(VIN_OFF) : int'(pg_off[ch]);
        ov  = (ch == VRAILS) ? 'hFFF : int'(ov_th[ch]);
        case ($urandom_range(0, 7))
            0: v = on;
            1: v = on - 1;
            2: v = off;
            3: v = off - 1;
            4: v = ov;
            5: v = ov + 1;
            6: v = $urandom_range(0, 'h3FF);
            default: v = $urandom_range(0, 'hFFF);
        endcase
        return 12'(v);
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        int          ns, k, r, n;
        logic [3:0]  ch;
        logic [11:0] v;

        RESET_N = 1'b0; ADC_VALID = 1'b0; ADC_CHANNEL = '0; ADC_DATA = '0;
        CLR_FAULTS = 1'b0; VMON_ENA = '0;
        for (int i = 0; i < VRAILS; i++) begin
            pg_on[i] = 12'h700; pg_off[i] = 12'h680; ov_th[i] = 12'hC00;
        end
        m_reset();
        repeat (2) step();
        check("rst_ready", 32'(ADC_READY), 32'd0);
        check("rst_vin_fault", 32'(VIN_FAULT), 32'd1);
        check_all("rst");
        RESET_N = 1'b1;
        step();
        check("ready_up", 32'(ADC_READY), 32'd1);

        // rail0 ramp; PWRGD rises two clocks after the third qualifying sample
        send(4'd0, 12'h000); send(4'd0, 12'h400);
        send(4'd0, 12'h800); send(4'd0, 12'h800); send(4'd0, 12'h800);
        ADC_VALID = 1'b0;
        check("t1_lat0", 32'(VRAIL_PWRGD[0]), 32'd0);
        step();
        check("t1_lat1", 32'(VRAIL_PWRGD[0]), 32'd0);
        step();
        check("t1_lat2", 32'(VRAIL_PWRGD[0]), 32'd1);
        idle(2);
        check_all("t1");

        // in-band sample breaks the falling run
        send(4'd0, 12'h600); send(4'd0, 12'h6A0); send(4'd0, 12'h600); send(4'd0, 12'h600);
        idle(3);
        check("t2_pg0", 32'(VRAIL_PWRGD[0]), 32'd1);
        check_all("t2");

        // UV only when the rail is enabled
        VMON_ENA = 4'b0010;
        repeat (3) send(4'd1, 12'h800);
        idle(3);
        check("t3_pg1_up", 32'(VRAIL_PWRGD[1]), 32'd1);
        repeat (3) send(4'd1, 12'h100);
        idle(3);
        check("t3_pg1_down", 32'(VRAIL_PWRGD[1]), 32'd0);
        check("t3_uv1", 32'(UV_FLAG[1]), 32'd1);
        check_all("t3a");
        clr_pulse();
        check("t3_uv_clr", 32'(UV_FLAG), 32'd0);
        VMON_ENA = 4'b0000;
        repeat (3) send(4'd1, 12'h800);
        repeat (3) send(4'd1, 12'h100);
        idle(3);
        check("t3_uv1_dis", 32'(UV_FLAG[1]), 32'd0);
        check_all("t3b");

        // OV set wins over a clear landing before it takes effect
        send(4'd2, 12'hC01); send(4'd2, 12'hC01);
        CLR_FAULTS = 1'b1;
        m_clear();
        send(4'd2, 12'hC01);
        CLR_FAULTS = 1'b0;
        idle(3);
        check("t4_ov2", 32'(OV_FLAG[2]), 32'd1);
        idle(4);
        check("t4_ov2_hold", 32'(OV_FLAG[2]), 32'd1);
        check_all("t4");

        // VIN hysteresis and bad channel
        repeat (3) send(4'(VRAILS), 12'hA00);
        idle(3);
        check("t5_vin_good", 32'(VIN_FAULT), 32'd0);
        repeat (3) send(4'(VRAILS), 12'h97F);
        idle(3);
        check("t5_vin_bad", 32'(VIN_FAULT), 32'd1);
        send(4'hF, 12'h123);
        idle(3);
        check("t5_bad_chan", 32'(BAD_CHAN), 32'd1);
        check_all("t5");

        // reset with samples in flight
        send(4'd0, 12'h100); send(4'd3, 12'hFFF);
        RESET_N = 1'b0;
        ADC_VALID = 1'b0;
        step();
        m_reset();
        check("t6_ready", 32'(ADC_READY), 32'd0);
        check("t6_vin_fault", 32'(VIN_FAULT), 32'd1);
        check_all("t6a");
        repeat (3) step();
        check_all("t6b");
        RESET_N = 1'b1;
        step();

        // randomized bursts
        for (int b = 0; b < 60; b++) begin
            if ($urandom_range(0, 2) == 0) begin
                r = $urandom_range(0, VRAILS - 1);
                pg_on[r]  = 12'($urandom_range('h100, 'hF00));
                pg_off[r] = pg_on[r] - 12'($urandom_range(0, 'h80));
                ov_th[r]  = 12'($urandom_range(int'(pg_on[r]), 'hFFF));
            end
            VMON_ENA = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 5) == 0) clr_pulse();
            ns = $urandom_range(1, 6);
            for (int s = 0; s < ns; s++) begin
                n = $urandom_range(0, 19);
                ch = (n == 19) ? 4'($urandom_range(VRAILS + 1, 15)) : 4'(n % (VRAILS + 1));
                v = (ch <= 4'(VRAILS)) ? pick_val(int'(ch)) : 12'($urandom_range(0, 'hFFF));
                k = $urandom_range(1, 4);
                for (int j = 0; j < k; j++) begin
                    send(ch, v);
                    if ($urandom_range(0, 4) == 0) idle(1);
                end
            end
            idle(3);
            check_all("rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
